// File: rtl/matrix_result_streamer_pkg.sv
// Shared types and display constants for the matrix result streaming path.
package matrix_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SHOW = 1'b1
    } stream_state_t;

    localparam int DEFAULT_ELEM_WIDTH = 14;

    // Two-digit display: anything beyond this shows as 99 with overflow set.
    localparam logic [3:0] DIGIT_SAT = 4'd9;
    localparam int         DISP_MAX  = 99;

endpackage

// File: rtl/matrix_result_streamer_if.sv
// Control/data bundle between the result streamer and the board display/IO logic.
interface matrix_result_streamer_if #(
    parameter int ELEM_WIDTH = 14,
    parameter int NUM_ELEMS  = 2
);
    localparam int IDX_WIDTH = (NUM_ELEMS > 1) ? $clog2(NUM_ELEMS) : 1;

    logic                            start;
    logic [NUM_ELEMS*ELEM_WIDTH-1:0] matrix_in;
    logic                            next;
    logic [ELEM_WIDTH-1:0]           elem;
    logic [IDX_WIDTH-1:0]            index;
    logic                            neg;
    logic [3:0]                      tens;
    logic [3:0]                      ones;
    logic                            overflow;
    logic                            valid;
    logic                            busy;
    logic                            done;

    modport master (
        output start, matrix_in, next,
        input  elem, index, neg, tens, ones, overflow, valid, busy, done
    );

    modport slave (
        input  start, matrix_in, next,
        output elem, index, neg, tens, ones, overflow, valid, busy, done
    );

endinterface

// File: rtl/matrix_result_streamer_digit_saturate.sv
// Signed value to sign + two decimal digits, saturating at 99 (also used for the determinant display).
module digit_saturate
    import matrix_pkg::*;
#(
    parameter int ELEM_WIDTH = DEFAULT_ELEM_WIDTH
) (
    input  logic [ELEM_WIDTH-1:0] i_value,
    output logic                  o_neg,
    output logic [3:0]            o_tens,
    output logic [3:0]            o_ones,
    output logic                  o_overflow
);
    localparam logic [ELEM_WIDTH-1:0] MOST_NEG = {1'b1, {(ELEM_WIDTH-1){1'b0}}};

    logic [ELEM_WIDTH-1:0] w_abs;
    logic [6:0]            w_small;

    assign o_neg = i_value[ELEM_WIDTH-1];
    assign w_abs = o_neg ? (~i_value + 1'b1) : i_value;

    // The most negative value negates to itself, so it is flagged explicitly.
    assign o_overflow = (i_value == MOST_NEG) || (w_abs > ELEM_WIDTH'(DISP_MAX));

    assign w_small = w_abs[6:0];
    assign o_tens  = o_overflow ? DIGIT_SAT : 4'(w_small / 7'd10);
    assign o_ones  = o_overflow ? DIGIT_SAT : 4'(w_small % 7'd10);

endmodule

// File: rtl/matrix_result_streamer.sv
// Captures a packed result vector on start and presents one element per rising edge of next.
module matrix_result_streamer
    import matrix_pkg::*;
#(
    parameter int ELEM_WIDTH = DEFAULT_ELEM_WIDTH,
    parameter int NUM_ELEMS  = 2,
    parameter int IDX_WIDTH  = (NUM_ELEMS > 1) ? $clog2(NUM_ELEMS) : 1
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    matrix_result_streamer_if.slave  bus
);
    localparam int                   VEC_WIDTH = NUM_ELEMS * ELEM_WIDTH;
    localparam logic [IDX_WIDTH-1:0] LAST_IDX  = IDX_WIDTH'(NUM_ELEMS - 1);

    stream_state_t          r_state, w_state_nxt;
    logic [VEC_WIDTH-1:0]   r_shadow, w_shadow_nxt;
    logic [IDX_WIDTH-1:0]   r_index, w_index_nxt;
    logic                   r_next_q;
    logic                   r_done, w_done_nxt;
    logic                   w_rise;
    logic                   w_valid;
    logic [ELEM_WIDTH-1:0]  w_elem;
    logic                   w_neg, w_overflow;
    logic [3:0]             w_tens, w_ones;

    // next_q tracks the button in every state, so a press held across start never advances.
    assign w_rise = bus.next & ~r_next_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= IDLE;
            r_shadow <= '0;
            r_index  <= '0;
            r_next_q <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_shadow <= w_shadow_nxt;
            r_index  <= w_index_nxt;
            r_next_q <= bus.next;
            r_done   <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_shadow_nxt = r_shadow;
        w_index_nxt  = r_index;
        w_done_nxt   = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_shadow_nxt = bus.matrix_in;
                    w_index_nxt  = '0;
                    w_state_nxt  = SHOW;
                end
            end
            SHOW: begin
                if (w_rise) begin
                    if (r_index == LAST_IDX) begin
                        w_state_nxt = IDLE;
                        w_index_nxt = '0;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_index_nxt = r_index + 1'b1;
                    end
                end
            end
        endcase
    end

    assign w_valid = (r_state == SHOW);
    // Zeroing elem while idle also zeroes neg/tens/ones/overflow out of the converter.
    assign w_elem  = w_valid ? r_shadow[r_index*ELEM_WIDTH +: ELEM_WIDTH] : '0;

    digit_saturate #(
        .ELEM_WIDTH (ELEM_WIDTH)
    ) u_digits (
        .i_value    (w_elem),
        .o_neg      (w_neg),
        .o_tens     (w_tens),
        .o_ones     (w_ones),
        .o_overflow (w_overflow)
    );

    assign bus.elem     = w_elem;
    assign bus.index    = w_valid ? r_index : '0;
    assign bus.neg      = w_neg;
    assign bus.tens     = w_tens;
    assign bus.ones     = w_ones;
    assign bus.overflow = w_overflow;
    assign bus.valid    = w_valid;
    assign bus.busy     = w_valid;
    assign bus.done     = r_done;

endmodule

// File: tb/tb_matrix_result_streamer.sv
// Directed scenarios plus randomized traffic, checked every cycle against a queue-based model.
module tb_matrix_result_streamer;

    localparam int EW      = 14;
    localparam int NE      = 2;
    localparam int MIN_VAL = -(1 << (EW - 1));

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    matrix_result_streamer_if #(.ELEM_WIDTH(EW), .NUM_ELEMS(NE)) bus ();

    matrix_result_streamer #(
        .ELEM_WIDTH (EW),
        .NUM_ELEMS  (NE)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    // Model: remaining elements of the active stream sit in a queue; the front is on display.
    int exp_q[$];
    int exp_idx       = 0;
    bit exp_active    = 1'b0;
    bit exp_done      = 1'b0;
    bit prev_next     = 1'b0;

    function automatic int elem_of(logic [NE*EW-1:0] vec, int k);
        logic signed [EW-1:0] e;
        e = vec[k*EW +: EW];
        return int'(e);
    endfunction

    function automatic void exp_digits(input int v, output bit n, output int t, output int o,
                                       output bit ov);
        int a;
        n = (v < 0);
        a = (v < 0) ? -v : v;
        if (v == MIN_VAL || a > 99) begin
            ov = 1'b1; t = 9; o = 9;
        end else begin
            ov = 1'b0; t = a / 10; o = a % 10;
        end
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin : model
        bit rise;
        rise     = bus.next && !prev_next;
        exp_done = 1'b0;
        if (rst) begin
            exp_q.delete();
            exp_active = 1'b0;
            exp_idx    = 0;
            prev_next  = 1'b0;
        end else begin
            prev_next = bus.next;
            if (!exp_active) begin
                if (bus.start) begin
                    exp_q.delete();
                    for (int k = 0; k < NE; k++) exp_q.push_back(elem_of(bus.matrix_in, k));
                    exp_idx    = 0;
                    exp_active = 1'b1;
                end
            end else if (rise) begin
                void'(exp_q.pop_front());
                exp_idx++;
                if (exp_q.size() == 0) begin
                    exp_active = 1'b0;
                    exp_idx    = 0;
                    exp_done   = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin : compare
        int v, t, o;
        bit n, ov;
        logic [EW-1:0] ev;
        if (chk_en) begin
            v  = exp_active ? exp_q[0] : 0;
            ev = EW'(v);
            exp_digits(v, n, t, o, ov);
            check("valid",    32'(bus.valid),    32'(exp_active));
            check("busy",     32'(bus.busy),     32'(exp_active));
            check("done",     32'(bus.done),     32'(exp_done));
            check("index",    32'(bus.index),    exp_active ? 32'(exp_idx) : 32'd0);
            check("elem",     32'(bus.elem),     32'(ev));
            check("neg",      32'(bus.neg),      32'(n));
            check("tens",     32'(bus.tens),     32'(t));
            check("ones",     32'(bus.ones),     32'(o));
            check("overflow", 32'(bus.overflow), 32'(ov));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press();
        bus.next = 1'b1;
        tick();
        bus.next = 1'b0;
        tick();
    endtask

    task automatic begin_stream(input logic [NE*EW-1:0] m);
        bus.matrix_in = m;
        bus.start     = 1'b1;
        tick();
        bus.start     = 1'b0;
    endtask

    function automatic int pick_elem();
        int sel;
        sel = $urandom_range(0, 3);
        case (sel)
            0:       return $urandom_range(0, 240) - 120;
            1:       return elem_of(NE*EW'($urandom), 0);
            2:       return MIN_VAL;
            default: begin
                int edges[6];
                edges = '{99, 100, -99, -100, 0, -1};
                return edges[$urandom_range(0, 5)];
            end
        endcase
    endfunction

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1);
    end

    initial begin : stimulus
        logic [NE*EW-1:0] vec;
        bus.start     = 1'b0;
        bus.next      = 1'b0;
        bus.matrix_in = '0;
        rst           = 1'b1;
        tick();
        chk_en = 1'b1;
        tick();
        check("rst_valid", 32'(bus.valid), 32'd0);
        check("rst_busy",  32'(bus.busy),  32'd0);
        check("rst_elem",  32'(bus.elem),  32'd0);
        rst = 1'b0;
        tick();

        // 1: slope 3, intercept 0
        begin_stream({14'd3, 14'd0});
        check("t1_valid", 32'(bus.valid), 32'd1);
        check("t1_idx0",  32'(bus.index), 32'd0);
        check("t1_elem0", 32'(bus.elem),  32'd0);
        check("t1_ones0", 32'(bus.ones),  32'd0);
        bus.next = 1'b1;
        tick();
        check("t1_idx1",  32'(bus.index), 32'd1);
        check("t1_elem1", 32'(bus.elem),  32'd3);
        check("t1_ones1", 32'(bus.ones),  32'd3);
        bus.next = 1'b0;
        tick();
        bus.next = 1'b1;
        tick();
        check("t1_done",      32'(bus.done),  32'd1);
        check("t1_end_valid", 32'(bus.valid), 32'd0);
        check("t1_end_busy",  32'(bus.busy),  32'd0);
        bus.next = 1'b0;
        tick();
        check("t1_done_once", 32'(bus.done), 32'd0);

        // 2: saturated positive, then small negative
        begin_stream({-14'sd42, 14'd157});
        check("t2_elem0", 32'(bus.elem),     32'd157);
        check("t2_ovf0",  32'(bus.overflow), 32'd1);
        check("t2_tens0", 32'(bus.tens),     32'd9);
        check("t2_ones0", 32'(bus.ones),     32'd9);
        check("t2_neg0",  32'(bus.neg),      32'd0);
        press();
        check("t2_elem1", 32'(bus.elem),     32'h3FD6);
        check("t2_neg1",  32'(bus.neg),      32'd1);
        check("t2_tens1", 32'(bus.tens),     32'd4);
        check("t2_ones1", 32'(bus.ones),     32'd2);
        check("t2_ovf1",  32'(bus.overflow), 32'd0);
        press();

        // 3: most negative value
        begin_stream({14'd5, 14'h2000});
        check("t3_neg",  32'(bus.neg),      32'd1);
        check("t3_ovf",  32'(bus.overflow), 32'd1);
        check("t3_tens", 32'(bus.tens),     32'd9);
        check("t3_ones", 32'(bus.ones),     32'd9);
        press();
        press();

        // 4: held button advances once; button held across start advances never
        begin_stream({14'd8, 14'd9});
        bus.next = 1'b1;
        repeat (20) tick();
        check("t4_held_idx",   32'(bus.index), 32'd1);
        check("t4_held_valid", 32'(bus.valid), 32'd1);
        bus.next = 1'b0;
        tick();
        press();
        bus.next = 1'b1;
        tick();
        begin_stream({14'd8, 14'd9});
        repeat (3) tick();
        check("t4_across_start_idx", 32'(bus.index), 32'd0);
        bus.next = 1'b0;
        tick();
        bus.next = 1'b1;
        tick();
        check("t4_repress_idx", 32'(bus.index), 32'd1);
        bus.next = 1'b0;
        tick();
        press();

        // 5: shadow held during SHOW; start beats rise in IDLE
        begin_stream({14'd7, 14'd11});
        bus.matrix_in = {14'd50, 14'd60};
        bus.start     = 1'b1;
        tick();
        bus.start     = 1'b0;
        check("t5_shadow_held", 32'(bus.elem), 32'd11);
        press();
        check("t5_shadow_elem1", 32'(bus.elem), 32'd7);
        press();
        bus.start = 1'b1;
        bus.next  = 1'b1;
        tick();
        bus.start = 1'b0;
        check("t5_start_wins_valid", 32'(bus.valid), 32'd1);
        check("t5_start_wins_idx",   32'(bus.index), 32'd0);
        check("t5_start_wins_elem",  32'(bus.elem),  32'd60);
        bus.next = 1'b0;
        tick();
        press();
        check("t5_second_elem", 32'(bus.elem), 32'd50);
        press();

        // 6: reset mid-stream, then a clean restart
        begin_stream({14'd12, 14'd34});
        press();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_rst_valid", 32'(bus.valid), 32'd0);
        check("t6_rst_elem",  32'(bus.elem),  32'd0);
        check("t6_rst_done",  32'(bus.done),  32'd0);
        tick();
        check("t6_no_done", 32'(bus.done), 32'd0);
        begin_stream({14'd20, 14'd19});
        check("t6_restart_idx",  32'(bus.index), 32'd0);
        check("t6_restart_tens", 32'(bus.tens),  32'd1);
        check("t6_restart_ones", 32'(bus.ones),  32'd9);
        press();
        check("t6_restart_elem1", 32'(bus.elem), 32'd20);
        check("t6_restart_tens1", 32'(bus.tens), 32'd2);
        press();

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            rst       = ($urandom_range(0, 199) == 0);
            bus.start = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 3) == 0) bus.next = ~bus.next;
            for (int k = 0; k < NE; k++) vec[k*EW +: EW] = EW'(pick_elem());
            bus.matrix_in = vec;
            tick();
        end
        rst       = 1'b0;
        bus.start = 1'b0;
        bus.next  = 1'b0;
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
